uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
Parametrised UART receiver. Oversamples the serial line using an external baud-tick enable and recovers frames with configurable data width, parity and stop bits. Each bit is decided by a 3-sample majority vote. Received words and their per-word error flags are buffered in a small FIFO and delivered through a valid/ready handshake. Sits between the pad-level rx line and the consuming datapath/controller; it replaces the fixed 8N1 receive datapath.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; LSB first on the line.
OVERSAMPLE, 16, baud_tick pulses per bit period; even, >= 8.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd; ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits checked; 1 or 2.
FIFO_DEPTH, 4, receive FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
baud_tick  in  1  one-clk enable pulse, OVERSAMPLE per bit period
rx  in  1  asynchronous serial input, idle high
rx_data  out  DATA_BITS  FIFO head word (show-ahead)
rx_frame_err  out  1  FIFO head word: a stop bit was sampled low
rx_parity_err  out  1  FIFO head word: parity mismatch (0 when PARITY_EN = 0)
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts the head word when rx_valid && rx_ready
overrun  out  1  one-clk pulse: a completed word was dropped because the FIFO was full
fifo_count  out  $clog2(FIFO_DEPTH+1)  number of occupied entries
busy  out  1  FSM not in IDLE

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: all outputs 0; synchronizer flops 1; FSM in IDLE; FIFO empty.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s and are evaluated only on cycles where baud_tick = 1.
- Tick counter tc runs 0..OVERSAMPLE-1 per bit and wraps to 0 at the bit boundary. M = OVERSAMPLE/2.
- Sampling: rx_s is captured at tc = M-1, M and M+1. The bit value is the majority of the 3 samples, decided at tc = M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on a tick with rx_s = 0 -> START with tc = 0.
  - START: if the majority is 1 (false start or glitch) -> IDLE at the decision tick. Otherwise continue until tc wraps -> DATA.
  - DATA: shift each majority bit in LSB first. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: parity_err = (XOR of data bits ^ parity bit ^ PARITY_ODD) != 0.
  - STOP: evaluate STOP_BITS bits. frame_err = any stop bit majority = 0.
- End of frame is the decision tick of the last stop bit; no wait for the bit end. On that tick the FSM pushes {data, frame_err, parity_err}.
  - If frame_err = 0 -> IDLE, so a back-to-back start bit can be detected early.
  - If frame_err = 1 -> WAIT_IDLE, which stays there until a tick sees rx_s = 1, then -> IDLE. A break condition therefore yields exactly one word.
- FIFO:
  - push happens on the end-of-frame cycle; pop = rx_valid && rx_ready.
  - rx_valid, rx_data and the error flags reflect the head in the cycle after the push (1-clk latency from the decision tick).
  - Push when full with no pop: the word is dropped, overrun pulses 1 clk, and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both are accepted, count unchanged, no overrun.
  - Push and pop in the same cycle when empty: the push is accepted and the pop is ignored (rx_valid was 0).
  - Read and write pointers wrap modulo FIFO_DEPTH; fifo_count is 0..FIFO_DEPTH.
- rx_ready has no effect while rx_valid = 0. Outputs hold while rx_valid && !rx_ready.
- Reset mid-frame: the partial frame is discarded, FIFO is emptied and the FSM restarts in IDLE. No spurious word is delivered if rx is high after reset.
- baud_tick held 0: the FSM and counters freeze; the FIFO still pops normally.

Test Plan:
- Default 8N1, OVERSAMPLE=16: send 0xA5 -> exactly one rx_valid word; rx_data = 0xA5, both error flags 0; valid rises 1 clk after the stop-bit decision tick.
- Start glitch: rx low for 4 ticks, then high -> FSM returns to IDLE; no push; fifo_count stays 0.
- PARITY_EN=1, even parity: send 0x3C with parity bit 1 -> rx_data = 0x3C, rx_parity_err = 1. Send it with parity bit 0 -> parity_err = 0.
- Framing and break: 0x55 with the stop bit low, then rx held low for 20 bit periods -> one word with rx_frame_err = 1. No further words until rx goes high and a new frame is sent.
- Overrun with rx_ready=0, FIFO_DEPTH=4: send 0x01..0x05 -> fifo_count = 4, one overrun pulse on the 5th frame. Then hold rx_ready=1 -> pops 0x01, 0x02, 0x03, 0x04 in order.
- Assert reset mid-data of 0x7E, release with rx idle -> all outputs 0, no word. A following 0x81 is received correctly. DATA_BITS=9, STOP_BITS=2: 0x1FF passes; a low second stop bit gives frame_err = 1.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, oversampled 3-sample majority bit recovery,
// configurable data/parity/stop framing, and a show-ahead receive FIFO with overrun flag.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             baud_tick,
  input  logic                             rx,
  output logic [DATA_BITS-1:0]             rx_data,
  output logic                             rx_frame_err,
  output logic                             rx_parity_err,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic                             overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             busy
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int WW  = DATA_BITS + 2;

  localparam logic [TCW-1:0] TC_S0    = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TC_S1    = TCW'(OVERSAMPLE / 2);
  localparam logic [TCW-1:0] TC_DEC   = TCW'(OVERSAMPLE / 2 + 1);
  localparam logic [TCW-1:0] TC_LAST  = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_DAT = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STP = BCW'(STOP_BITS - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  function automatic logic f_majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                 r_rx_meta, r_rx_s;
  state_t               r_state, w_state_nxt;
  logic [TCW-1:0]       r_tc;
  logic [BCW-1:0]       r_bitcnt;
  logic                 r_frame_err, r_par_err;
  logic                 r_s0, r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic [WW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_overrun;

  logic          w_maj, w_dec, w_wrap, w_push, w_frame_err_fin;
  logic          w_pop, w_full, w_wr;
  logic [WW-1:0] w_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // The third sample is the live synchronized line at the decision tick.
  assign w_maj           = f_majority(r_s0, r_s1, r_rx_s);
  assign w_dec           = baud_tick && (r_tc == TC_DEC);
  assign w_wrap          = baud_tick && (r_tc == TC_LAST);
  assign w_frame_err_fin = r_frame_err | ~w_maj;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE:   if (baud_tick && !r_rx_s) w_state_nxt = S_START;
      S_START: begin
        if (w_dec && w_maj) w_state_nxt = S_IDLE;
        else if (w_wrap)    w_state_nxt = S_DATA;
      end
      S_DATA:   if (w_wrap && r_bitcnt == LAST_DAT)
                  w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_wrap) w_state_nxt = S_STOP;
      // Frame ends at the last stop decision so a back-to-back start is not missed.
      S_STOP: begin
        if (w_dec && r_bitcnt == LAST_STP) begin
          w_push      = 1'b1;
          w_state_nxt = w_frame_err_fin ? S_WAIT_IDLE : S_IDLE;
        end
      end
      S_WAIT_IDLE: if (baud_tick && r_rx_s) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tc        <= '0;
      r_bitcnt    <= '0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else if (baud_tick) begin
      if (r_state == S_IDLE || r_state == S_WAIT_IDLE) begin
        r_tc        <= '0;
        r_bitcnt    <= '0;
        r_frame_err <= 1'b0;
        r_par_err   <= 1'b0;
      end else begin
        r_tc <= w_wrap ? '0 : r_tc + 1'b1;
        if (w_wrap && r_state == S_DATA)
          r_bitcnt <= (r_bitcnt == LAST_DAT) ? '0 : r_bitcnt + 1'b1;
        else if (w_wrap && r_state == S_STOP)
          r_bitcnt <= r_bitcnt + 1'b1;
        if (w_dec && r_state == S_PARITY)
          r_par_err <= (PARITY_EN != 0) && ((^r_shift) ^ w_maj ^ (PARITY_ODD != 0));
        if (w_dec && r_state == S_STOP)
          r_frame_err <= w_frame_err_fin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (baud_tick && r_tc == TC_S0) r_s0 <= r_rx_s;
    if (baud_tick && r_tc == TC_S1) r_s1 <= r_rx_s;
    if (w_dec && r_state == S_DATA) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
    if (w_wr) r_mem[r_wr_ptr] <= {r_shift, w_frame_err_fin, r_par_err};
  end

  // Receive FIFO: a full push is admitted only when a pop frees the head slot.
  assign w_pop  = rx_valid && rx_ready;
  assign w_full = (r_count == FULL_CNT);
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign rx_valid      = (r_count != '0);
  assign rx_data       = rx_valid ? w_head[WW-1:2] : '0;
  assign rx_frame_err  = rx_valid & w_head[1];
  assign rx_parity_err = rx_valid & w_head[0];
  assign overrun       = r_overrun;
  assign fifo_count    = r_count;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: an 8N1 instance and a 9-bit even-parity two-stop instance,
// driven with directed frames from a vector table plus hand-written corner sequences.
module tb_uart_rx_core;

  localparam int BITCLK = 32;

  logic clk = 1'b0;
  logic rst_n, baud_tick;
  logic rx_a, rdy_a, ferr_a, perr_a, vld_a, ovr_a, busy_a;
  logic [7:0] data_a;
  logic [2:0] cnt_a;
  logic rx_b, rdy_b, ferr_b, perr_b, vld_b, ovr_b, busy_b;
  logic [8:0] data_b;
  logic [2:0] cnt_b;

  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1 baud_tick = ~baud_tick;
    end
  end

  uart_rx_core u_a (
    .clk(clk), .reset(rst_n), .baud_tick(baud_tick), .rx(rx_a),
    .rx_data(data_a), .rx_frame_err(ferr_a), .rx_parity_err(perr_a),
    .rx_valid(vld_a), .rx_ready(rdy_a), .overrun(ovr_a),
    .fifo_count(cnt_a), .busy(busy_a)
  );

  uart_rx_core #(.DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(rst_n), .baud_tick(baud_tick), .rx(rx_b),
    .rx_data(data_b), .rx_frame_err(ferr_b), .rx_parity_err(perr_b),
    .rx_valid(vld_b), .rx_ready(rdy_b), .overrun(ovr_b),
    .fifo_count(cnt_b), .busy(busy_b)
  );

  // Pop monitor: records every accepted word and valid-rise timing per instance.
  logic [8:0] got_d_a [64];
  logic       got_f_a [64];
  logic       got_p_a [64];
  logic [8:0] got_d_b [64];
  logic       got_f_b [64];
  logic       got_p_b [64];
  int got_n_a = 0, got_n_b = 0, n_ovr_a = 0, n_ovr_b = 0;
  int n_rise_ok_a = 0, n_rise_ok_b = 0;
  logic pv_a = 1'b0, pb_a = 1'b0, pv_b = 1'b0, pb_b = 1'b0;

  always @(negedge clk) begin
    if (vld_a && rdy_a && got_n_a < 64) begin
      got_d_a[got_n_a] <= {1'b0, data_a};
      got_f_a[got_n_a] <= ferr_a;
      got_p_a[got_n_a] <= perr_a;
      got_n_a <= got_n_a + 1;
    end
    if (vld_b && rdy_b && got_n_b < 64) begin
      got_d_b[got_n_b] <= data_b;
      got_f_b[got_n_b] <= ferr_b;
      got_p_b[got_n_b] <= perr_b;
      got_n_b <= got_n_b + 1;
    end
    if (ovr_a) n_ovr_a <= n_ovr_a + 1;
    if (ovr_b) n_ovr_b <= n_ovr_b + 1;
    if (vld_a && !pv_a && pb_a && !busy_a) n_rise_ok_a <= n_rise_ok_a + 1;
    if (vld_b && !pv_b && pb_b && !busy_b) n_rise_ok_b <= n_rise_ok_b + 1;
    pv_a <= vld_a;
    pb_a <= busy_a;
    pv_b <= vld_b;
    pb_b <= busy_b;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input bit inst, input logic v);
    if (inst) rx_b = v;
    else      rx_a = v;
    repeat (BITCLK) @(posedge clk);
    #1;
  endtask

  // Instance A frames are 8N1; instance B frames are 9 data bits, parity, 2 stops.
  task automatic send_frame(input bit inst, input logic [8:0] d, input logic par,
                            input logic s1, input logic s2);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < (inst ? 9 : 8); i++) drive_bit(inst, d[i]);
    if (inst) drive_bit(inst, par);
    drive_bit(inst, s1);
    if (inst) drive_bit(inst, s2);
    drive_bit(inst, 1'b1);
    drive_bit(inst, 1'b1);
  endtask

  typedef struct {
    bit         inst;
    logic [8:0] data;
    logic       par;
    logic       s1;
    logic       s2;
    logic [8:0] exp_d;
    logic       exp_f;
    logic       exp_p;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rb, n;
    logic [8:0] d;
    logic f, p;

    vecs[0] = '{1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 9'h0FF, 1'b0, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 9'h055, 1'b0, 1'b0, 1'b1, 9'h055, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 9'h03C, 1'b1, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 9'h03C, 1'b0, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 9'h1FF, 1'b1, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 9'h1FF, 1'b1, 1'b1, 1'b0, 9'h1FF, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 9'h0A6, 1'b1, 1'b0, 1'b1, 9'h0A6, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 9'h081, 1'b0, 1'b1, 1'b1, 9'h081, 1'b0, 1'b0};

    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_valid_a", 32'(vld_a), 0);
    chk("rst_data_a", 32'(data_a), 0);
    chk("rst_errs_a", 32'({ferr_a, perr_a}), 0);
    chk("rst_ovr_a", 32'(ovr_a), 0);
    chk("rst_cnt_a", 32'(cnt_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_out_b", 32'({vld_b, data_b, ferr_b, perr_b, ovr_b, cnt_b, busy_b}), 0);
    rst_n = 1'b1;
    repeat (BITCLK) @(posedge clk);
    #1;
    chk("idle_after_rst", 32'({vld_a, busy_a, vld_b, busy_b}), 0);

    for (int i = 0; i < 10; i++) begin
      base = vecs[i].inst ? got_n_b : got_n_a;
      rb   = vecs[i].inst ? n_rise_ok_b : n_rise_ok_a;
      send_frame(vecs[i].inst, vecs[i].data, vecs[i].par, vecs[i].s1, vecs[i].s2);
      n = (vecs[i].inst ? got_n_b : got_n_a) - base;
      chk($sformatf("v%0d_words", i), n, 1);
      d = vecs[i].inst ? got_d_b[base] : got_d_a[base];
      f = vecs[i].inst ? got_f_b[base] : got_f_a[base];
      p = vecs[i].inst ? got_p_b[base] : got_p_a[base];
      chk($sformatf("v%0d_data", i), 32'(d), 32'(vecs[i].exp_d));
      chk($sformatf("v%0d_ferr", i), 32'(f), 32'(vecs[i].exp_f));
      chk($sformatf("v%0d_perr", i), 32'(p), 32'(vecs[i].exp_p));
      chk($sformatf("v%0d_busy_end", i), 32'(vecs[i].inst ? busy_b : busy_a), 0);
      if (!vecs[i].exp_f)
        chk($sformatf("v%0d_valid_latency", i),
            (vecs[i].inst ? n_rise_ok_b : n_rise_ok_a) - rb, 1);
    end

    // Start glitch: 4 ticks low must be rejected after detection.
    base = got_n_a;
    rx_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("glitch_detect_busy", 32'(busy_a), 1);
    @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (2 * BITCLK) @(posedge clk);
    #1;
    chk("glitch_busy", 32'(busy_a), 0);
    chk("glitch_cnt", 32'(cnt_a), 0);
    chk("glitch_words", got_n_a - base, 0);

    // Bad stop bit followed by a 20-bit break yields exactly one word.
    base = got_n_a;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'b0, (i % 2) == 0);
    for (int i = 0; i < 21; i++) drive_bit(1'b0, 1'b0);
    chk("break_words", got_n_a - base, 1);
    chk("break_data", 32'(got_d_a[base]), 32'h55);
    chk("break_ferr", 32'(got_f_a[base]), 1);
    chk("break_busy", 32'(busy_a), 1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    chk("break_recover_busy", 32'(busy_a), 0);
    send_frame(1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1);
    chk("break_next_words", got_n_a - base, 2);
    chk("break_next_data", 32'(got_d_a[base+1]), 32'hA5);
    chk("break_next_ferr", 32'(got_f_a[base+1]), 0);

    // Overrun: five frames into a four-deep FIFO with no consumer.
    rdy_a = 1'b0;
    base  = got_n_a;
    rb    = n_ovr_a;
    for (int k = 1; k <= 4; k++) send_frame(1'b0, 9'(k), 1'b0, 1'b1, 1'b1);
    chk("ovr_cnt4", 32'(cnt_a), 4);
    chk("ovr_none_yet", n_ovr_a - rb, 0);
    send_frame(1'b0, 9'h005, 1'b0, 1'b1, 1'b1);
    chk("ovr_pulse", n_ovr_a - rb, 1);
    chk("ovr_cnt_hold", 32'(cnt_a), 4);
    chk("ovr_head_valid", 32'(vld_a), 1);
    chk("ovr_head_data", 32'(data_a), 32'h01);
    rdy_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("ovr_drained", got_n_a - base, 4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("ovr_pop%0d", j), 32'(got_d_a[base+j]), 32'(j + 1));
    chk("ovr_cnt_empty", 32'(cnt_a), 0);

    // Reset during a frame with a word already queued.
    rdy_a = 1'b0;
    send_frame(1'b0, 9'h033, 1'b0, 1'b1, 1'b1);
    chk("mid_pre_cnt", 32'(cnt_a), 1);
    base = got_n_a;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    chk("mid_busy", 32'(busy_a), 1);
    rst_n = 1'b0;
    rx_a  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_outs", 32'({vld_a, data_a, ferr_a, perr_a, ovr_a, cnt_a, busy_a}), 0);
    rst_n = 1'b1;
    rdy_a = 1'b1;
    repeat (2 * BITCLK) @(posedge clk);
    #1;
    chk("mid_no_word", got_n_a - base, 0);
    chk("mid_idle_outs", 32'({vld_a, cnt_a, busy_a}), 0);
    send_frame(1'b0, 9'h081, 1'b0, 1'b1, 1'b1);
    chk("mid_next_words", got_n_a - base, 1);
    chk("mid_next_data", 32'(got_d_a[base]), 32'h81);
    chk("mid_next_errs", 32'({got_f_a[base], got_p_a[base]}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
